mat_add_sub_seq: RTL and testbench

MAT_ADD_SUB_SEQ -- requirements
Module: mat_add_sub_seq

---
 rtl/mat_add_sub_seq.sv | 130 +++++++++++++
 tb/tb_mat_add_sub_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_add_sub_seq.sv
// Sequential square-matrix add/subtract engine, one row of DIM elements per clock.
// Build option: define MAT_SATURATE_EN to clamp overflowing elements instead of wrapping.
module mat_add_sub_seq #(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned DIM    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [DIM*DIM*ELEM_W-1:0]  m1,
    input  logic [DIM*DIM*ELEM_W-1:0]  m2,
    output logic [DIM*DIM*ELEM_W-1:0]  m_out,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    localparam int unsigned ROW_BITS = DIM * ELEM_W;
    localparam int unsigned MAT_BITS = DIM * ROW_BITS;
    localparam int unsigned ROW_W    = $clog2(DIM);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [MAT_BITS-1:0] m1_q;
    logic [MAT_BITS-1:0] m2_q;
    logic [1:0]          op_q;
    logic [ROW_W-1:0]    row_q;
    logic                last_row;

    logic [ROW_BITS-1:0] row_res;
    logic                row_ovf;
    logic [ELEM_W-1:0]   elem_a;
    logic [ELEM_W-1:0]   elem_b;
    logic [ELEM_W:0]     wide;
    logic                elem_ovf;

    assign last_row = (row_q == ROW_W'(DIM - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One row of results; the sum is formed one bit wider so sign overflow is visible
    always_comb begin
        row_res  = '0;
        row_ovf  = 1'b0;
        elem_a   = '0;
        elem_b   = '0;
        wide     = '0;
        elem_ovf = 1'b0;
        for (int c = 0; c < int'(DIM); c++) begin
            elem_a = m1_q[(int'(row_q) * int'(DIM) + c) * int'(ELEM_W) +: ELEM_W];
            elem_b = m2_q[(int'(row_q) * int'(DIM) + c) * int'(ELEM_W) +: ELEM_W];
            case (op_q)
                2'b00:   wide = {elem_a[ELEM_W-1], elem_a} + {elem_b[ELEM_W-1], elem_b};
                2'b01:   wide = {elem_a[ELEM_W-1], elem_a} - {elem_b[ELEM_W-1], elem_b};
                2'b10:   wide = {elem_b[ELEM_W-1], elem_b} - {elem_a[ELEM_W-1], elem_a};
                default: wide = {elem_a[ELEM_W-1], elem_a};
            endcase
            elem_ovf = wide[ELEM_W] ^ wide[ELEM_W-1];
`ifdef MAT_SATURATE_EN
            if (elem_ovf) begin
                row_res[c*int'(ELEM_W) +: ELEM_W] = wide[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                                                 : {1'b0, {(ELEM_W-1){1'b1}}};
            end else begin
                row_res[c*int'(ELEM_W) +: ELEM_W] = wide[ELEM_W-1:0];
            end
`else
            row_res[c*int'(ELEM_W) +: ELEM_W] = wide[ELEM_W-1:0];
`endif
            row_ovf = row_ovf | elem_ovf;
        end
    end

    // Operand capture, row writeback and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m1_q     <= '0;
            m2_q     <= '0;
            op_q     <= '0;
            row_q    <= '0;
            m_out    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        m1_q     <= m1;
                        m2_q     <= m2;
                        op_q     <= op;
                        row_q    <= '0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    m_out[int'(row_q) * int'(ROW_BITS) +: ROW_BITS] <= row_res;
                    overflow <= overflow | row_ovf;
                    if (!last_row) begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_add_sub_seq.sv
// Self-checking bench for mat_add_sub_seq: integer reference model, cycle-by-cycle row checks.
module tb_mat_add_sub_seq;

    localparam int unsigned W    = 16;
    localparam int unsigned D    = 4;
    localparam int unsigned ROWB = W * D;
    localparam int unsigned MB   = W * D * D;
    localparam int unsigned W2   = 8;
    localparam int unsigned D2   = 3;
    localparam int unsigned MB2  = W2 * D2 * D2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start;
    logic [1:0]    op;
    logic [MB-1:0] m1, m2, m_out;
    logic          busy, done, overflow;

    logic           p_start;
    logic [1:0]     p_op;
    logic [MB2-1:0] p_m1, p_m2, p_m_out;
    logic           p_busy, p_done, p_overflow;

    mat_add_sub_seq #(.ELEM_W(W), .DIM(D)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .m1(m1), .m2(m2),
        .m_out(m_out), .busy(busy), .done(done), .overflow(overflow)
    );

    mat_add_sub_seq #(.ELEM_W(W2), .DIM(D2)) u_small (
        .clk(clk), .reset(reset), .start(p_start), .op(p_op), .m1(p_m1), .m2(p_m2),
        .m_out(p_m_out), .busy(p_busy), .done(p_done), .overflow(p_overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [255:0] cur_exp;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic longint elem(input logic [255:0] m, input int idx, input int w);
        logic [255:0] t;
        longint v;
        t = (m >> (idx * w)) & ((256'(1) << w) - 256'(1));
        v = longint'(t[63:0]);
        if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    // Reference: plain integer arithmetic, then range check against the signed element range
    task automatic model(input logic [255:0] a, input logic [255:0] b, input logic [1:0] o,
                         input int w, input int d,
                         output logic [255:0] res, output logic [15:0] rovf);
        longint x, y, z, mx, mn;
        int idx;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        res = '0;
        rovf = '0;
        for (int r = 0; r < d; r++) begin
            for (int c = 0; c < d; c++) begin
                idx = r * d + c;
                x = elem(a, idx, w);
                y = elem(b, idx, w);
                case (o)
                    2'd0:    z = x + y;
                    2'd1:    z = x - y;
                    2'd2:    z = y - x;
                    default: z = x;
                endcase
                if (z > mx || z < mn) begin
                    rovf[r] = 1'b1;
`ifdef MAT_SATURATE_EN
                    z = (z > mx) ? mx : mn;
`endif
                end
                res = res | ((256'(z) & ((256'(1) << w) - 256'(1))) << (idx * w));
            end
        end
    endtask

    function automatic logic [255:0] rand_mat(input int mode);
        logic [255:0] m;
        logic [15:0]  e;
        m = '0;
        for (int i = 0; i < int'(D * D); i++) begin
            if (mode == 0) begin
                e = 16'($urandom_range(0, 1000));
            end else begin
                case ($urandom_range(0, 4))
                    0:       e = 16'h7FFF;
                    1:       e = 16'h8000;
                    2:       e = 16'hFFFF;
                    3:       e = 16'h0001;
                    default: e = 16'($urandom);
                endcase
            end
            m[i*16 +: 16] = e;
        end
        return m;
    endfunction

    // Drives one operation and checks every cycle from acceptance to one cycle past done
    task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [1:0] o,
                          input bit inject, output logic [255:0] res);
        logic [255:0] want, prev, expm;
        logic [15:0]  rovf;
        logic         ovf_exp;
        model(a, b, o, W, D, expm, rovf);
        prev = cur_exp;
        m1 = a; m2 = b; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m1 = rand_mat(1); m2 = rand_mat(1); op = 2'($urandom);
        chk("accept_busy", 256'(busy), 256'(1));
        chk("accept_done", 256'(done), 256'(0));
        chk("accept_mout", m_out, prev);
        chk("accept_ovf", 256'(overflow), 256'(0));
        for (int k = 1; k <= int'(D) + 1; k++) begin
            if (inject && k == 3) begin
                start = 1'b1;
                m1 = ~a;
            end
            if (inject && k == 4) start = 1'b0;
            @(posedge clk); #1;
            want = prev;
            ovf_exp = 1'b0;
            for (int r = 0; r < int'(D); r++) begin
                if (r < k) begin
                    want[r*ROWB +: ROWB] = expm[r*ROWB +: ROWB];
                    ovf_exp = ovf_exp | rovf[r];
                end
            end
            chk($sformatf("mout_e%0d", k), m_out, want);
            chk($sformatf("busy_e%0d", k), 256'(busy), 256'(k <= int'(D)));
            chk($sformatf("done_e%0d", k), 256'(done), 256'(k == int'(D) + 1));
            chk($sformatf("ovf_e%0d", k), 256'(overflow), 256'(ovf_exp));
        end
        @(posedge clk); #1;
        chk("hold_done", 256'(done), 256'(0));
        chk("hold_busy", 256'(busy), 256'(0));
        chk("hold_mout", m_out, expm);
        cur_exp = expm;
        res = expm;
    endtask

    initial begin
        logic [255:0] a, b, res, mres;
        logic [15:0]  rovf;
        logic [MB2-1:0] lit;
        int cnt;

        reset = 1'b1; start = 1'b0; op = '0; m1 = '0; m2 = '0;
        p_start = 1'b0; p_op = '0; p_m1 = '0; p_m2 = '0;
        cur_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mout", m_out, 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        reset = 1'b0;

        // Directed add / subtract with hand-computed row 0
        a = rand_mat(0); b = rand_mat(0);
        a[63:0] = {16'd18, 16'd19, 16'd14, 16'd11};
        b[63:0] = {16'd2, 16'd9, 16'd8, 16'd5};
        run_op(a, b, 2'b00, 1'b0, res);
        chk("add_row0", 256'(res[63:0]), 256'({16'd20, 16'd28, 16'd22, 16'd16}));
        chk("add_row0_dut", 256'(m_out[63:0]), 256'({16'd20, 16'd28, 16'd22, 16'd16}));
        chk("add_ovf", 256'(overflow), 256'(0));
        run_op(a, b, 2'b01, 1'b0, res);
        chk("sub01_row0", 256'(m_out[63:0]), 256'({16'd16, 16'd10, 16'd6, 16'd6}));
        run_op(a, b, 2'b10, 1'b0, res);
        chk("sub10_row0", 256'(m_out[63:0]),
            256'({16'hFFF0, 16'hFFF6, 16'hFFFA, 16'hFFFA}));
        run_op(a, b, 2'b11, 1'b0, res);
        chk("pass_mat", m_out, a);

        // Overflow corners
        a = rand_mat(0); b = rand_mat(0);
        a[15:0] = 16'h7FFF; b[15:0] = 16'h0001;
        run_op(a, b, 2'b00, 1'b0, res);
`ifdef MAT_SATURATE_EN
        chk("ovf_add_elem", 256'(m_out[15:0]), 256'(16'h7FFF));
`else
        chk("ovf_add_elem", 256'(m_out[15:0]), 256'(16'h8000));
`endif
        chk("ovf_add_flag", 256'(overflow), 256'(1));
        a[15:0] = 16'h8000;
        run_op(a, b, 2'b01, 1'b0, res);
`ifdef MAT_SATURATE_EN
        chk("ovf_sub_elem", 256'(m_out[15:0]), 256'(16'h8000));
`else
        chk("ovf_sub_elem", 256'(m_out[15:0]), 256'(16'h7FFF));
`endif
        chk("ovf_sub_flag", 256'(overflow), 256'(1));

        // Start re-pulsed during RUN must be ignored
        run_op(rand_mat(0), rand_mat(0), 2'b00, 1'b1, res);

        // Reset two edges into an operation
        m1 = rand_mat(1); m2 = rand_mat(1); op = 2'b00; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_mout", m_out, 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_ovf", 256'(overflow), 256'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_done", 256'(done), 256'(0));
        end
        reset = 1'b0;
        cur_exp = '0;
        run_op(rand_mat(1), rand_mat(1), 2'b01, 1'b0, res);

        // Randomized operations
        for (int t = 0; t < 25; t++) begin
            run_op(rand_mat(int'($urandom_range(0, 1))), rand_mat(int'($urandom_range(0, 1))),
                   2'($urandom), ($urandom_range(0, 3) == 0), res);
        end

        // Smaller configuration: 8-bit elements, 3x3
        lit = '0;
        for (int i = 0; i < int'(D2 * D2); i++) begin
            p_m1[i*8 +: 8] = 8'd100;
            p_m2[i*8 +: 8] = 8'd50;
`ifdef MAT_SATURATE_EN
            lit[i*8 +: 8] = 8'h7F;
`else
            lit[i*8 +: 8] = 8'h96;
`endif
        end
        model(256'(p_m1), 256'(p_m2), 2'b00, W2, D2, mres, rovf);
        chk("small_model", mres, 256'(lit));
        p_op = 2'b00; p_start = 1'b1;
        @(posedge clk); #1;
        p_start = 1'b0;
        cnt = 0;
        while (!p_done && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("small_latency", 256'(cnt), 256'(D2 + 1));
        chk("small_mout", 256'(p_m_out), 256'(lit));
        chk("small_ovf", 256'(p_overflow), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
